// File: rtl/mem_port_arbiter.sv
// Arbitrates the unified single-ported memory between instruction fetch and data access.
// Data wins by default; a grant streak counter forces fetch progress; a watchdog aborts hung transactions.
module mem_port_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int TIMEOUT      = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_ack,
    input  logic        dm_req,
    input  logic        dm_we,
    input  logic [3:0]  dm_be,
    input  logic [31:0] dm_addr,
    input  logic [31:0] dm_wdata,
    output logic [31:0] dm_rdata,
    output logic        dm_ack,
    output logic        mem_req,
    output logic        mem_we,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic        bus_err
);

    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam int WW = $clog2(TIMEOUT);

    typedef enum logic [1:0] {IDLE, IF_BUSY, DM_BUSY} state_t;

    state_t        state, state_n;
    logic [SW-1:0] streak, streak_n;
    logic [WW-1:0] wdog, wdog_n;

    logic          mem_req_n, mem_we_n, if_ack_n, dm_ack_n, bus_err_n;
    logic [3:0]    mem_be_n;
    logic [31:0]   mem_addr_n, mem_wdata_n, if_rdata_n, dm_rdata_n;
    logic          starve, own_if;

    assign starve = if_req && (streak == SW'(STARVE_LIMIT));
    assign own_if = (state == IF_BUSY);

    always_comb begin
        state_n     = state;
        streak_n    = streak;
        wdog_n      = wdog;
        mem_req_n   = mem_req;
        mem_we_n    = mem_we;
        mem_be_n    = mem_be;
        mem_addr_n  = mem_addr;
        mem_wdata_n = mem_wdata;
        if_rdata_n  = if_rdata;
        dm_rdata_n  = dm_rdata;
        if_ack_n    = 1'b0;
        dm_ack_n    = 1'b0;
        bus_err_n   = 1'b0;
        unique case (state)
            IDLE: begin
                if (dm_req && !starve) begin
                    state_n     = DM_BUSY;
                    wdog_n      = '0;
                    mem_req_n   = 1'b1;
                    mem_we_n    = dm_we;
                    mem_be_n    = dm_be;
                    mem_addr_n  = dm_addr;
                    mem_wdata_n = dm_wdata;
                    if (!if_req)
                        streak_n = '0;
                    else if (streak != SW'(STARVE_LIMIT))
                        streak_n = streak + 1'b1;
                end else if (if_req) begin
                    state_n     = IF_BUSY;
                    wdog_n      = '0;
                    streak_n    = '0;
                    mem_req_n   = 1'b1;
                    mem_we_n    = 1'b0;
                    mem_be_n    = 4'hF;
                    mem_addr_n  = if_addr;
                    mem_wdata_n = '0;
                end else begin
                    streak_n = '0;
                end
            end
            IF_BUSY, DM_BUSY: begin
                if (mem_ack) begin
                    state_n   = IDLE;
                    mem_req_n = 1'b0;
                    if (own_if) begin
                        if_ack_n   = 1'b1;
                        if_rdata_n = mem_rdata;
                    end else begin
                        dm_ack_n   = 1'b1;
                        dm_rdata_n = mem_we ? 32'h0 : mem_rdata;
                    end
                end else if (wdog == WW'(TIMEOUT - 1)) begin
                    // hung memory: release the bus and report the abort
                    state_n   = IDLE;
                    mem_req_n = 1'b0;
                    bus_err_n = 1'b1;
                    if (own_if) begin
                        if_ack_n   = 1'b1;
                        if_rdata_n = '0;
                    end else begin
                        dm_ack_n   = 1'b1;
                        dm_rdata_n = '0;
                    end
                end else begin
                    wdog_n = wdog + 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            streak    <= '0;
            wdog      <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_be    <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            if_rdata  <= '0;
            dm_rdata  <= '0;
            if_ack    <= 1'b0;
            dm_ack    <= 1'b0;
            bus_err   <= 1'b0;
        end else begin
            state     <= state_n;
            streak    <= streak_n;
            wdog      <= wdog_n;
            mem_req   <= mem_req_n;
            mem_we    <= mem_we_n;
            mem_be    <= mem_be_n;
            mem_addr  <= mem_addr_n;
            mem_wdata <= mem_wdata_n;
            if_rdata  <= if_rdata_n;
            dm_rdata  <= dm_rdata_n;
            if_ack    <= if_ack_n;
            dm_ack    <= dm_ack_n;
            bus_err   <= bus_err_n;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: fetch, starvation, store, timeout, reset abort.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic [31:0] if_rdata;
    logic        if_ack;
    logic        dm_req = 1'b0;
    logic        dm_we = 1'b0;
    logic [3:0]  dm_be = 4'hF;
    logic [31:0] dm_addr = '0;
    logic [31:0] dm_wdata = '0;
    logic [31:0] dm_rdata;
    logic        dm_ack;
    logic        mem_req;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = '0;
    logic        mem_ack;
    logic        bus_err;

    logic        auto_ack = 1'b0;
    logic        auto_q = 1'b0;
    logic        man_ack = 1'b0;

    int n_chk = 0;
    int n_fail = 0;

    mem_port_arbiter #(.STARVE_LIMIT(4), .TIMEOUT(64)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
        .dm_req(dm_req), .dm_we(dm_we), .dm_be(dm_be), .dm_addr(dm_addr),
        .dm_wdata(dm_wdata), .dm_rdata(dm_rdata), .dm_ack(dm_ack),
        .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    // memory that answers one cycle after seeing mem_req (k=1)
    always @(negedge clk) auto_q <= auto_ack && mem_req;
    assign mem_ack = auto_q | man_ack;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic wait_mreq(input logic lvl, input string tag);
        int n;
        n = 0;
        while (mem_req !== lvl && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n == 20) check(tag, {31'b0, mem_req}, {31'b0, lvl});
    endtask

    task automatic wait_ack(input bit dm, input string tag, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(dm ? dm_ack : if_ack) && n < 200);
        if (!(dm ? dm_ack : if_ack)) check(tag, 32'd0, 32'd1);
    endtask

    logic [31:0] addrs [6];
    logic [31:0] exp_addrs [6];
    int n;

    initial begin
        exp_addrs = '{32'h300, 32'h300, 32'h300, 32'h300, 32'h200, 32'h300};

        // reset state
        repeat (3) @(negedge clk);
        check("rst_mem_req", {31'b0, mem_req}, 32'd0);
        check("rst_acks", {29'b0, if_ack, dm_ack, bus_err}, 32'd0);
        check("rst_rdata", if_rdata | dm_rdata, 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        rst = 1'b1;
        @(negedge clk);

        // single fetch
        auto_ack = 1'b1;
        mem_rdata = 32'h00500293;
        if_addr = 32'h10;
        if_req = 1'b1;
        wait_ack(1'b0, "t1_if_ack_timeout", n);
        if_req = 1'b0;
        check("t1_latency", n, 32'd2);
        check("t1_if_rdata", if_rdata, 32'h00500293);
        check("t1_dm_ack", {31'b0, dm_ack}, 32'd0);
        check("t1_bus_err", {31'b0, bus_err}, 32'd0);
        @(negedge clk);
        check("t1_ack_pulse", {30'b0, if_ack, dm_ack}, 32'd0);
        repeat (2) @(negedge clk);

        // both requests held: DM x4, forced IF, then DM
        if_addr = 32'h200;
        dm_addr = 32'h300;
        dm_we = 1'b0;
        dm_be = 4'hF;
        if_req = 1'b1;
        dm_req = 1'b1;
        for (int i = 0; i < 6; i++) begin
            wait_mreq(1'b1, "t2_grant_timeout");
            addrs[i] = mem_addr;
            wait_mreq(1'b0, "t2_done_timeout");
        end
        if_req = 1'b0;
        dm_req = 1'b0;
        for (int i = 0; i < 6; i++)
            check($sformatf("t2_grant%0d", i), addrs[i], exp_addrs[i]);
        repeat (4) @(negedge clk);

        // plain load
        mem_rdata = 32'hCAFEF00D;
        dm_addr = 32'h44;
        dm_req = 1'b1;
        wait_mreq(1'b1, "t_ld_grant_timeout");
        check("ld_mem_we", {31'b0, mem_we}, 32'd0);
        check("ld_mem_addr", mem_addr, 32'h44);
        wait_ack(1'b1, "t_ld_ack_timeout", n);
        dm_req = 1'b0;
        check("ld_dm_rdata", dm_rdata, 32'hCAFEF00D);
        @(negedge clk);

        // store with fields held until ack
        auto_ack = 1'b0;
        dm_we = 1'b1;
        dm_be = 4'b0011;
        dm_addr = 32'h100;
        dm_wdata = 32'hDEADBEEF;
        dm_req = 1'b1;
        wait_mreq(1'b1, "t3_grant_timeout");
        check("t3_mem_we", {31'b0, mem_we}, 32'd1);
        check("t3_mem_be", {28'b0, mem_be}, 32'h3);
        check("t3_mem_addr", mem_addr, 32'h100);
        check("t3_mem_wdata", mem_wdata, 32'hDEADBEEF);
        dm_addr = 32'h999;
        dm_wdata = 32'h0;
        repeat (3) @(negedge clk);
        check("t3_hold_addr", mem_addr, 32'h100);
        check("t3_hold_wdata", mem_wdata, 32'hDEADBEEF);
        check("t3_hold_req", {31'b0, mem_req}, 32'd1);
        man_ack = 1'b1;
        @(negedge clk);
        man_ack = 1'b0;
        check("t3_dm_ack", {31'b0, dm_ack}, 32'd1);
        check("t3_dm_rdata", dm_rdata, 32'd0);
        check("t3_mem_req", {31'b0, mem_req}, 32'd0);
        dm_req = 1'b0;
        dm_we = 1'b0;
        dm_be = 4'hF;
        @(negedge clk);
        check("t3_ack_pulse", {31'b0, dm_ack}, 32'd0);

        // watchdog abort
        mem_rdata = 32'h12345678;
        dm_addr = 32'h40;
        dm_req = 1'b1;
        wait_mreq(1'b1, "t4_grant_timeout");
        wait_ack(1'b1, "t4_ack_timeout", n);
        dm_req = 1'b0;
        check("t4_cycles", n, 32'd64);
        check("t4_bus_err", {31'b0, bus_err}, 32'd1);
        check("t4_mem_req", {31'b0, mem_req}, 32'd0);
        check("t4_dm_rdata", dm_rdata, 32'd0);
        @(negedge clk);
        check("t4_err_pulse", {30'b0, bus_err, dm_ack}, 32'd0);

        // reset mid-transaction, late memory ack ignored
        dm_addr = 32'h80;
        dm_req = 1'b1;
        wait_mreq(1'b1, "t5_grant_timeout");
        rst = 1'b0;
        dm_req = 1'b0;
        @(negedge clk);
        check("t5_mem_req", {31'b0, mem_req}, 32'd0);
        check("t5_mem_addr", mem_addr, 32'd0);
        check("t5_outs", {29'b0, if_ack, dm_ack, bus_err}, 32'd0);
        rst = 1'b1;
        @(negedge clk);
        man_ack = 1'b1;
        @(negedge clk);
        man_ack = 1'b0;
        check("t5_stale_ack", {30'b0, if_ack, dm_ack}, 32'd0);
        check("t5_stale_req", {31'b0, mem_req}, 32'd0);
        @(negedge clk);
        check("t5_stale_ack2", {30'b0, if_ack, dm_ack}, 32'd0);
        auto_ack = 1'b1;
        mem_rdata = 32'h00A00313;
        if_addr = 32'h20;
        if_req = 1'b1;
        wait_ack(1'b0, "t5_if_timeout", n);
        if_req = 1'b0;
        check("t5_if_latency", n, 32'd2);
        check("t5_if_rdata", if_rdata, 32'h00A00313);
        repeat (2) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
